uart_line_echo: RTL and testbench
=================================

Name: uart_line_echo

Overview:
- Parametrised successor to the single-byte rx2tx bridge. Sits between the UART RX FIFO read port and the UART TX FIFO write port.
- Passthrough mode echoes each byte as it arrives.
- Line modes collect bytes into an internal buffer until a terminator arrives, then emit the line to TX: as-is, reversed, or upper-cased.
- Buffer depth, data width and terminator are parameters.

Parameters:
DATA_W  8  byte width; transforms act on the 8 LSBs, and DATA_W must be at least 8
DEPTH  64  line buffer capacity in bytes, power of 2, minimum 4
TERM  8'h0D  line terminator, compared against the 8 LSBs
AW  $clog2(DEPTH)  local: buffer index width

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
mode  in  2  0=passthrough, 1=line echo, 2=line reverse, 3=line uppercase
rx_fifo_dout  in  DATA_W  RX FIFO head data (first-word-fall-through; valid while !rx_fifo_empty)
rx_fifo_empty  in  1  RX FIFO empty
rx_fifo_rd_en  out  1  pop RX FIFO head this cycle
tx_fifo_din  out  DATA_W  TX FIFO write data
tx_fifo_full  in  1  TX FIFO full
tx_fifo_wr_en  out  1  write tx_fifo_din this cycle
busy  out  1  high in EMIT, or in COLLECT while count>0
overflow  out  1  one-cycle pulse when a line is force-flushed at DEPTH

Behaviour:
- Single clock and async active-low reset.
- Reset values: rx_fifo_rd_en=0, tx_fifo_wr_en=0, tx_fifo_din=0, busy=0, overflow=0, state=COLLECT, count=0, line mode register=0.
- Reset mid-line or mid-emit discards the buffer. No partial output follows reset.

FIFO handshake:
- rx_fifo_rd_en is never asserted while rx_fifo_empty=1.
- tx_fifo_wr_en is never asserted while tx_fifo_full=1.
- Each asserted cycle is exactly one pop or one push.

Line mode capture:
- A registered copy of mode (lmode) is captured only in COLLECT with count=0, on the cycle the first byte of a line is popped.
- mode changes mid-line or mid-emit take effect at the next line boundary.
- While idle (COLLECT, count=0), the live mode selects passthrough vs line behaviour.

PASSTHROUGH (COLLECT, count=0, mode=0):
- rx_fifo_rd_en = !rx_fifo_empty && !tx_fifo_full.
- tx_fifo_wr_en = rx_fifo_rd_en.
- tx_fifo_din = rx_fifo_dout.
- Combinational, zero latency, full throughput of one byte per cycle.
- The buffer is unused.

COLLECT (line modes):
- rx_fifo_rd_en = !rx_fifo_empty. One byte is popped per cycle.
- Non-TERM byte: written to buf[count], count++.
- TERM byte: not stored. Set term_flag=1 and go to EMIT next cycle.
- Overflow: if count reaches DEPTH after a write, go to EMIT with term_flag=0 and pulse overflow for one cycle. No further pop occurs that cycle.
- Overflow case: the next byte, including a TERM, starts a new line. A TERM arriving there yields an empty line, which emits TERM alone.

EMIT:
- Holding register hv/hd (valid/data). tx_fifo_wr_en = hv && !tx_fifo_full; tx_fifo_din = hd.
- Holding register loads whenever !hv or a write occurs this cycle.
- Emit order:
  - lmode 1 and 3: buf[0..count-1], then TERM if term_flag.
  - lmode 2: buf[count-1..0], then TERM if term_flag.
  - lmode 3: bytes 0x61..0x7A have 0x20 subtracted; all other bytes pass unchanged (TERM included).
- Latency: the first write is no later than 2 cycles after the TERM pop (or the overflow cycle), if the TX FIFO is not full.
- Sustained rate: one byte per cycle while !tx_fifo_full. A full TX FIFO stalls with hd held stable.
- rx_fifo_rd_en=0 throughout EMIT.
- After the last byte is accepted: count=0, go to COLLECT.
- An empty line (count=0, term_flag=1) emits exactly one TERM.

Test Plan:
- mode=0; RX holds 0x41,0x42,0x43 and TX is never full -> three consecutive wr_en cycles, din=0x41,0x42,0x43, each in the same cycle as its rd_en.
- mode=1; input "ab\r" (0x61,0x62,0x0D) -> TX receives 0x61,0x62,0x0D. First write ≤2 cycles after the 0x0D pop. No rd_en during EMIT.
- mode=2; input "abc\r" -> TX receives 0x63,0x62,0x61,0x0D. mode=3; input "a1Z\r" -> TX receives 0x41,0x31,0x5A,0x0D.
- mode=1, DEPTH=4; input 0x30..0x35 then 0x0D:
  - First 0x30..0x33 are emitted with no TERM and overflow pulses once.
  - Next line 0x34,0x35 is followed by 0x0D.
  - An input of 0x30..0x33,0x0D instead emits 0x30..0x33, then a lone 0x0D.
- mode=1; during EMIT hold tx_fifo_full high for 5 cycles mid-line and toggle mode to 2 -> wr_en stays low and din is stable while full. Output bytes are not lost or duplicated. The current line still emits in order, and the next line emits reversed.
- Assert rst_n low for 1 cycle mid-COLLECT (count=3) and again mid-EMIT -> all outputs return to reset values immediately. The next "x\r" emits only 0x78,0x0D.

Source files
------------

// File: rtl/uart_line_echo.sv
// uart_line_echo
// Bridges the UART RX FIFO read port to the UART TX FIFO write port.
//   mode 0 : passthrough, each byte is copied straight across in the cycle it is popped
//   mode 1 : collect a line up to TERM, then emit it unchanged, followed by TERM
//   mode 2 : collect a line, then emit it reversed, followed by TERM
//   mode 3 : collect a line, then emit it with a..z upper-cased, followed by TERM
// A line that fills the buffer is flushed without TERM, and overflow pulses.
//
// Ports
//   clk, rst_n        system clock, asynchronous active-low reset
//   mode              live mode; it is latched into lmode when a line starts
//   rx_fifo_dout      RX FIFO head data (first-word-fall-through)
//   rx_fifo_empty     RX FIFO empty
//   rx_fifo_rd_en     pop the RX FIFO head this cycle
//   tx_fifo_din       TX FIFO write data
//   tx_fifo_full      TX FIFO full
//   tx_fifo_wr_en     push tx_fifo_din this cycle
//   busy              a line is being collected or emitted
//   overflow          one-cycle pulse when a full buffer is force-flushed
//
// state   | meaning
// --------+-----------------------------------------------------------------
// COLLECT | idle (count=0): passthrough or wait for a line; count>0: storing a line
// EMIT    | replaying the buffer (and TERM) through the hv/hd holding register

module uart_line_echo #(
    parameter int          DATA_W = 8,
    parameter int          DEPTH  = 64,
    parameter logic [7:0]  TERM   = 8'h0D
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] rx_fifo_dout,
    input  logic              rx_fifo_empty,
    output logic              rx_fifo_rd_en,
    output logic [DATA_W-1:0] tx_fifo_din,
    input  logic              tx_fifo_full,
    output logic              tx_fifo_wr_en,
    output logic              busy,
    output logic              overflow
);

    localparam int          AW   = $clog2(DEPTH);
    localparam logic [AW:0] ONE  = (AW+1)'(1);
    localparam logic [AW:0] LAST = (AW+1)'(DEPTH - 1);

    typedef enum logic {COLLECT, EMIT} state_t;

    state_t            state, state_nxt;
    logic              run;
    logic [AW:0]       count;
    logic [AW:0]       eidx;
    logic [AW:0]       len;
    logic [1:0]        lmode;
    logic              term_flag;
    logic              hv;
    logic [DATA_W-1:0] hd;
    logic [DATA_W-1:0] emit_byte;
    logic [AW-1:0]     rd_idx;
    logic [DATA_W-1:0] line_buf [DEPTH];

    logic idle, pass, rx_is_term, line_pop, fill, load, done;

    assign idle       = (state == COLLECT) && (count == '0);
    assign pass       = run && idle && (mode == 2'd0);
    assign rx_is_term = (rx_fifo_dout[7:0] == TERM);
    assign line_pop   = rx_fifo_rd_en && !pass;
    assign fill       = line_pop && !rx_is_term && (count == LAST);
    // Number of bytes to emit: the stored bytes plus the TERM, if one ended the line.
    assign len        = count + {{AW{1'b0}}, term_flag};
    // The holding register refills whenever it is empty or is drained this cycle.
    assign load       = (state == EMIT) && (eidx != len) && (!hv || tx_fifo_wr_en);
    assign done       = (state == EMIT) && (eidx == len) && (!hv || tx_fifo_wr_en);
    assign busy       = (state == EMIT) || (count != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= COLLECT;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            COLLECT: if (line_pop && (rx_is_term || count == LAST)) state_nxt = EMIT;
            EMIT:    if (done) state_nxt = COLLECT;
            default: state_nxt = COLLECT;
        endcase
    end

    // run holds the bridge quiet until the first clock edge after reset is released.
    always_comb begin
        rx_fifo_rd_en = 1'b0;
        tx_fifo_wr_en = 1'b0;
        tx_fifo_din   = '0;
        if (run) begin
            case (state)
                COLLECT: begin
                    if (pass) begin
                        rx_fifo_rd_en = !rx_fifo_empty && !tx_fifo_full;
                        tx_fifo_wr_en = !rx_fifo_empty && !tx_fifo_full;
                        tx_fifo_din   = rx_fifo_dout;
                    end else begin
                        rx_fifo_rd_en = !rx_fifo_empty;
                    end
                end
                EMIT: begin
                    tx_fifo_wr_en = hv && !tx_fifo_full;
                    tx_fifo_din   = hd;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        rd_idx    = (lmode == 2'd2) ? AW'(count - eidx - ONE) : AW'(eidx);
        emit_byte = '0;
        if (eidx < count) begin
            emit_byte = line_buf[rd_idx];
            if (lmode == 2'd3 && emit_byte[7:0] >= 8'h61 && emit_byte[7:0] <= 8'h7A)
                emit_byte[7:0] = emit_byte[7:0] - 8'h20;
        end else begin
            emit_byte[7:0] = TERM;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run       <= 1'b0;
            overflow  <= 1'b0;
            count     <= '0;
            term_flag <= 1'b0;
            lmode     <= 2'd0;
            eidx      <= '0;
            hv        <= 1'b0;
            hd        <= '0;
        end else begin
            run      <= 1'b1;
            overflow <= fill;
            if (line_pop && count == '0) lmode <= mode;
            if (line_pop) term_flag <= rx_is_term;
            if (line_pop && !rx_is_term) count <= count + ONE;
            else if (done)               count <= '0;
            if (state == COLLECT) begin
                eidx <= '0;
                hv   <= 1'b0;
            end else if (load) begin
                eidx <= eidx + ONE;
                hv   <= 1'b1;
                hd   <= emit_byte;
            end else if (tx_fifo_wr_en) begin
                hv   <= 1'b0;
            end
        end
    end

    // Buffer contents need no reset: count gates every read.
    always_ff @(posedge clk) begin
        if (line_pop && !rx_is_term) line_buf[count[AW-1:0]] <= rx_fifo_dout;
    end

endmodule

// File: tb/tb_uart_line_echo.sv
module tb_uart_line_echo;

    logic       clk;
    logic       rst_n;
    logic [1:0] mode;
    logic [7:0] rx_fifo_dout;
    logic       rx_fifo_empty;
    logic       rx_fifo_rd_en;
    logic [7:0] tx_fifo_din;
    logic       tx_fifo_full;
    logic       tx_fifo_wr_en;
    logic       busy;
    logic       overflow;

    uart_line_echo #(.DATA_W(8), .DEPTH(4), .TERM(8'h0D)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .mode          (mode),
        .rx_fifo_dout  (rx_fifo_dout),
        .rx_fifo_empty (rx_fifo_empty),
        .rx_fifo_rd_en (rx_fifo_rd_en),
        .tx_fifo_din   (tx_fifo_din),
        .tx_fifo_full  (tx_fifo_full),
        .tx_fifo_wr_en (tx_fifo_wr_en),
        .busy          (busy),
        .overflow      (overflow)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int viol_rd = 0, viol_wr = 0;
    int ovf_cnt = 0, full_cyc = 0, unstable = 0;
    int full_hold = 0;
    bit stall_arm = 0;
    bit prev_full = 0;
    logic [7:0] prev_din = '0;
    logic s_rd, s_wr, s_busy, s_full;
    logic [7:0] s_din;

    logic [7:0] rx_q[$];
    logic [7:0] tx_q[$];
    int         tx_cyc[$];
    logic [7:0] rd_q[$];
    int         rd_cyc[$];

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive_rx();
        rx_fifo_empty = (rx_q.size() == 0);
        rx_fifo_dout  = (rx_q.size() == 0) ? 8'h00 : rx_q[0];
    endtask

    task automatic push_str(string s);
        for (int i = 0; i < s.len(); i++) rx_q.push_back(s[i]);
        drive_rx();
    endtask

    task automatic clear_logs();
        tx_q.delete(); tx_cyc.delete(); rd_q.delete(); rd_cyc.delete();
        ovf_cnt = 0; full_cyc = 0; unstable = 0;
    endtask

    // One clock: sample away from the edge, then update the FIFO models after it.
    task automatic tick();
        @(negedge clk);
        cyc++;
        s_rd = rx_fifo_rd_en; s_wr = tx_fifo_wr_en; s_din = tx_fifo_din;
        s_busy = busy; s_full = tx_fifo_full;
        if (s_rd && rx_fifo_empty) viol_rd++;
        if (s_wr && tx_fifo_full)  viol_wr++;
        if (overflow) ovf_cnt++;
        if (s_full) begin
            full_cyc++;
            if (prev_full && s_din !== prev_din) unstable++;
        end
        prev_full = s_full; prev_din = s_din;
        if (s_wr) begin tx_q.push_back(s_din); tx_cyc.push_back(cyc); end
        if (s_rd) begin rd_q.push_back(rx_fifo_dout); rd_cyc.push_back(cyc); end
        @(posedge clk); #1;
        if (s_rd && rx_q.size() > 0) void'(rx_q.pop_front());
        if (stall_arm && s_wr) begin
            full_hold = 5; stall_arm = 0; mode = 2'd2;
        end else if (full_hold > 0) begin
            full_hold--;
        end
        tx_fifo_full = (full_hold > 0);
        drive_rx();
    endtask

    task automatic run_idle(string tag);
        int idle = 0;
        int n = 0;
        while (idle < 3 && n < 200) begin
            tick();
            n++;
            idle = (rx_q.size() == 0 && !s_busy && !s_wr) ? idle + 1 : 0;
        end
        chk({tag, "_settled"}, (idle >= 3), 1);
    endtask

    task automatic chk_str(string tag, string s);
        chk({tag, "_len"}, tx_q.size(), s.len());
        for (int i = 0; i < s.len() && i < tx_q.size(); i++)
            chk($sformatf("%s_%0d", tag, i), tx_q[i], s[i]);
    endtask

    // One-cycle reset pulse with a non-empty RX head so that a gated rd_en is visible.
    task automatic do_reset(string tag);
        @(negedge clk);
        rst_n = 0; rx_fifo_empty = 0; rx_fifo_dout = 8'h55;
        tx_fifo_full = 0; full_hold = 0; stall_arm = 0;
        #1;
        chk({tag, "_rd_en"}, rx_fifo_rd_en, 0);
        chk({tag, "_wr_en"}, tx_fifo_wr_en, 0);
        chk({tag, "_din"},   tx_fifo_din,   0);
        chk({tag, "_busy"},  busy,          0);
        chk({tag, "_ovf"},   overflow,      0);
        @(negedge clk);
        rst_n = 1;
        rx_q.delete();
        drive_rx();
    endtask

    initial begin
        clk = 0; rst_n = 0; mode = 2'd0; tx_fifo_full = 0;
        rx_fifo_empty = 1; rx_fifo_dout = 8'h00;
        do_reset("rst0");
        tick(); tick();

        // passthrough
        clear_logs(); mode = 2'd0; push_str("ABC"); run_idle("pt");
        chk_str("pt_data", "ABC");
        chk("pt_rd_cnt", rd_q.size(), 3);
        if (tx_cyc.size() == 3 && rd_cyc.size() == 3) begin
            chk("pt_b2b",   tx_cyc[2] - tx_cyc[0], 2);
            chk("pt_same0", tx_cyc[0], rd_cyc[0]);
            chk("pt_same2", tx_cyc[2], rd_cyc[2]);
        end

        // line echo, two lines back to back
        clear_logs(); mode = 2'd1; push_str("ab\015cd\015"); run_idle("echo");
        chk_str("echo_data", "ab\015cd\015");
        if (tx_cyc.size() >= 3 && rd_cyc.size() >= 4) begin
            chk("echo_lat",   (tx_cyc[0] - rd_cyc[2]) <= 2, 1);
            chk("echo_no_rd", rd_cyc[3] > tx_cyc[2], 1);
        end

        // reverse and uppercase (with a..z boundary neighbours)
        clear_logs(); mode = 2'd2; push_str("abc\015"); run_idle("rev");
        chk_str("rev_data", "cba\015");
        clear_logs(); mode = 2'd3; push_str("a1Z\015`z{\015"); run_idle("up");
        chk_str("up_data", "A1Z\015`Z{\015");

        // overflow at DEPTH=4
        clear_logs(); mode = 2'd1; push_str("012345\015"); run_idle("ovf1");
        chk_str("ovf1_data", "012345\015");
        chk("ovf1_pulse", ovf_cnt, 1);
        clear_logs(); push_str("0123\015"); run_idle("ovf2");
        chk_str("ovf2_data", "0123\015");
        chk("ovf2_pulse", ovf_cnt, 1);

        // TX stall mid-line with a mode change to reverse
        clear_logs(); mode = 2'd1; stall_arm = 1; push_str("abc\015de\015"); run_idle("stall");
        chk_str("stall_data", "abc\015ed\015");
        chk("stall_full_cyc", full_cyc, 5);
        chk("stall_din_stable", unstable, 0);

        // reset mid-collect
        clear_logs(); mode = 2'd1; push_str("abc");
        for (int n = 0; n < 20 && rx_q.size() != 0; n++) tick();
        tick();
        chk("rc_busy_pre", s_busy, 1);
        do_reset("rc");
        clear_logs();
        repeat (5) tick();
        chk("rc_quiet", tx_q.size(), 0);
        chk("rc_idle", s_busy, 0);

        // reset mid-emit
        clear_logs(); mode = 2'd1; push_str("abc\015");
        for (int n = 0; n < 30 && tx_q.size() == 0; n++) tick();
        chk("re_started", (tx_q.size() > 0), 1);
        do_reset("re");
        clear_logs();
        repeat (5) tick();
        chk("re_quiet", tx_q.size(), 0);
        push_str("x\015"); run_idle("re_next");
        chk_str("re_next_data", "x\015");

        chk("proto_rd_empty", viol_rd, 0);
        chk("proto_wr_full",  viol_wr, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
